// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter
// Two-port round-robin front end for one shared combinational single-precision
// divider. Operands are registered and held for SETTLE_CYCLES so the divider
// can be timed as a multicycle path; the quotient and exception flag are then
// captured and returned on a shared response channel tagged with the requester.
// Optional build macro: FP_DIV_ZERO_BYPASS_EN -- zero divisors are answered
// locally (NaN or signed infinity, exception set) one cycle after accept.
module fp_div_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_exception,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_result,
    input  logic        div_exception,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_grant_r;
    logic [CNT_W-1:0] cnt_r;
    logic        grant_s;
    logic        sel_valid_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic        accept_s;
    logic        capture_s;
    logic        resp_hs_s;
    logic        bypass_s;
    logic [31:0] bypass_result_s;

    assign accept_s  = (state_r == ST_IDLE) && sel_valid_s;
    assign capture_s = (state_r == ST_WAIT) && (cnt_r == CNT_ZERO);
    assign resp_hs_s = (state_r == ST_RESP) && resp_ready;

`ifdef FP_DIV_ZERO_BYPASS_EN
    // A zero divisor (either sign) never needs the divider: 0/0 is NaN, x/0 is signed infinity.
    assign bypass_s        = accept_s && (sel_b_s[30:0] == 31'd0);
    assign bypass_result_s = (sel_a_s[30:0] == 31'd0) ? 32'h7FC0_0000
                                                      : {sel_a_s[31] ^ sel_b_s[31], 31'h7F80_0000};
`else
    assign bypass_s        = 1'b0;
    assign bypass_result_s = 32'h0000_0000;
`endif

    // Round-robin grant: a lone requester wins, contention goes to the port not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Steer the granted requester's valid and operands toward the operand registers.
    always_comb begin
        sel_valid_s = req0_valid;
        sel_a_s     = req0_a;
        sel_b_s     = req0_b;
        if (grant_s) begin
            sel_valid_s = req1_valid;
            sel_a_s     = req1_a;
            sel_b_s     = req1_b;
        end else begin
            sel_valid_s = req0_valid;
            sel_a_s     = req0_a;
            sel_b_s     = req0_b;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: accept, settle, then hold the response until consumed.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = bypass_s ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (capture_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: ready only in IDLE for the granted valid port, busy outside IDLE.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b0;
        if (state_r == ST_IDLE) begin
            req0_ready = ~grant_s & req0_valid;
            req1_ready = grant_s & req1_valid;
        end else begin
            busy = 1'b1;
        end
        resp_valid = (state_r == ST_RESP);
    end

    // Settle counter: loaded on accept, counts down to zero while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_WAIT) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand and tag registers: loaded on accept and held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a   <= 32'h0000_0000;
            div_b   <= 32'h0000_0000;
            resp_id <= 1'b0;
        end else if (accept_s) begin
            div_a   <= sel_a_s;
            div_b   <= sel_b_s;
            resp_id <= grant_s;
        end else begin
            div_a   <= div_a;
            div_b   <= div_b;
            resp_id <= resp_id;
        end
    end

    // Response capture: divider output after the settle window, or the local zero-divisor answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_result    <= 32'h0000_0000;
            resp_exception <= 1'b0;
        end else if (bypass_s) begin
            resp_result    <= bypass_result_s;
            resp_exception <= 1'b1;
        end else if (capture_s) begin
            resp_result    <= div_result;
            resp_exception <= div_exception;
        end else begin
            resp_result    <= resp_result;
            resp_exception <= resp_exception;
        end
    end

    // Fairness history: the port whose response was just consumed loses the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (resp_hs_s) begin
            last_grant_r <= resp_id;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Self-checking bench for fp_div_arbiter: table-driven single ops, contention,
// backpressure, reset during the settle window. A small lookup divider stands
// in for the real datapath; a scoreboard queue holds expected responses.
module tb_fp_div_arbiter;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_exception;
    logic [31:0] resp_result;
    logic [31:0] div_a, div_b, div_result;
    logic        div_exception;
    logic        busy;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    vec_t vt[8];
    exp_t sb[$];
    exp_t mon_e;
    logic order_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    fp_div_arbiter #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_exception(resp_exception),
        .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_exception(div_exception),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Lookup divider covering exactly the operand pairs the bench issues.
    always_comb begin
        div_result    = 32'hDEAD_BEEF;
        div_exception = 1'b0;
        case ({div_a, div_b})
            {32'h40C0_0000, 32'h4000_0000}: div_result = 32'h4040_0000;
            {32'h3F80_0000, 32'h4080_0000}: div_result = 32'h3E80_0000;
            {32'h3F80_0000, 32'h4000_0000}: div_result = 32'h3F00_0000;
            {32'h4100_0000, 32'h4000_0000}: div_result = 32'h4080_0000;
            {32'h0000_0000, 32'h0000_0000}: begin div_result = 32'h7FC0_0000; div_exception = 1'b1; end
            {32'h4040_0000, 32'h0000_0000}: begin div_result = 32'h7F80_0000; div_exception = 1'b1; end
            {32'hC040_0000, 32'h0000_0000}: begin div_result = 32'hFF80_0000; div_exception = 1'b1; end
            {32'hC040_0000, 32'h8000_0000}: begin div_result = 32'h7F80_0000; div_exception = 1'b1; end
            default: begin div_result = 32'hDEAD_BEEF; div_exception = 1'b0; end
        endcase
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef FP_DIV_ZERO_BYPASS_EN
        if (b[30:0] == 31'd0) return 0;
`endif
        return SETTLE;
    endfunction

    // Scoreboard monitor: every consumed response is matched against the oldest accept.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got id %b result %h, expected no response", resp_id, resp_result);
            end else begin
                mon_e = sb.pop_front();
                check1("resp_id", resp_id, mon_e.id);
                check32("resp_result", resp_result, mon_e.res);
                check1("resp_exception", resp_exception, mon_e.exc);
            end
        end
    end

    task automatic set_port(input logic port, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (port) begin req1_valid = v; req1_a = a; req1_b = b; end
        else begin req0_valid = v; req0_a = a; req0_b = b; end
    endtask

    // One request: wait for accept, check operand registers, measure edges to resp_valid.
    task automatic issue(input vec_t v);
        int n;
        int lat;
        @(posedge clk); #1;
        set_port(v.port, 1'b1, v.a, v.b);
        n = 0;
        @(negedge clk);
        while (!(v.port ? req1_ready : req0_ready) && n < 50) begin @(negedge clk); n++; end
        check1("accept", (n < 50), 1'b1);
        if (n < 50) sb.push_back('{v.port, v.res, v.exc});
        @(posedge clk); #1;
        set_port(v.port, 1'b0, v.a, v.b);
        @(negedge clk);
        check32("div_a", div_a, v.a);
        check32("div_b", div_b, v.b);
        lat = 0;
        while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
        check32("latency", 32'(lat), 32'(exp_lat(v.b)));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        check1("idle", (n < 100), 1'b1);
    endtask

    // Keeps one port requesting back to back for two operations.
    task automatic drive_port(input logic port, input int i0, input int i1);
        for (int k = 0; k < 2; k++) begin
            int n;
            vec_t v;
            if (k == 0) v = vt[i0];
            else v = vt[i1];
            set_port(port, 1'b1, v.a, v.b);
            n = 0;
            @(negedge clk);
            while (!(port ? req1_ready : req0_ready) && n < 100) begin @(negedge clk); n++; end
            check1("contend_accept", (n < 100), 1'b1);
            if (n < 100) begin
                sb.push_back('{port, v.res, v.exc});
                order_q.push_back(port);
            end
            @(posedge clk); #1;
        end
        set_port(port, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic exp_order[4];
        logic saw;
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        vt[0] = '{1'b0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
        vt[1] = '{1'b1, 32'h3F80_0000, 32'h4080_0000, 32'h3E80_0000, 1'b0};
        vt[2] = '{1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0};
        vt[3] = '{1'b1, 32'h4100_0000, 32'h4000_0000, 32'h4080_0000, 1'b0};
        vt[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1};
        vt[5] = '{1'b1, 32'h4040_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1};
        vt[6] = '{1'b0, 32'hC040_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1};
        vt[7] = '{1'b1, 32'hC040_0000, 32'h8000_0000, 32'h7F80_0000, 1'b1};

        // Reset state
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
        repeat (3) @(negedge clk);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check32("rst_div_a", div_a, 32'h0);
        check32("rst_div_b", div_b, 32'h0);
        check32("rst_resp_result", resp_result, 32'h0);
        check1("rst_resp_id", resp_id, 1'b0);
        check1("rst_resp_exception", resp_exception, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check1("idle_req0_ready", req0_ready, 1'b0);
        check1("idle_req1_ready", req1_ready, 1'b0);
        check1("idle_busy", busy, 1'b0);

        // Contention from reset: expect grants 0,1,0,1
        @(posedge clk); #1;
        fork
            drive_port(1'b0, 0, 2);
            drive_port(1'b1, 1, 3);
        join
        wait_idle();
        check32("order_len", 32'(order_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < order_q.size()) check1("grant_order", order_q[k], exp_order[k]);
        end

        // Table of single operations
        for (int i = 0; i < 8; i++) begin
            issue(vt[i]);
            wait_idle();
            check32("div_a_hold", div_a, vt[i].a);
            check32("div_b_hold", div_b, vt[i].b);
        end

        // Backpressure with a pending request on port 1
        @(posedge clk); #1; resp_ready = 1'b0;
        issue(vt[0]);
        @(posedge clk); #1; set_port(1'b1, 1'b1, vt[1].a, vt[1].b);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check1("bp_valid", resp_valid, 1'b1);
            check32("bp_result", resp_result, 32'h4040_0000);
            check1("bp_id", resp_id, 1'b0);
            check1("bp_exception", resp_exception, 1'b0);
            check1("bp_req1_ready", req1_ready, 1'b0);
            check1("bp_busy", busy, 1'b1);
        end
        @(posedge clk); #1; resp_ready = 1'b1;
        @(negedge clk);
        check1("bp_valid_last", resp_valid, 1'b1);
        @(negedge clk);
        check1("bp_done", resp_valid, 1'b0);
        check1("bp_pending_ready", req1_ready, 1'b1);
        if (req1_ready) sb.push_back('{1'b1, vt[1].res, vt[1].exc});
        @(posedge clk); #1; set_port(1'b1, 1'b0, 32'h0, 32'h0);
        wait_idle();

        // Reset two cycles into the settle window abandons the operation
        @(posedge clk); #1; set_port(1'b0, 1'b1, vt[2].a, vt[2].b);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!req0_ready && n < 50) begin @(negedge clk); n++; end
            check1("mid_accept", (n < 50), 1'b1);
        end
        @(posedge clk); #1; set_port(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_valid", resp_valid, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
        end
        check1("mid_rst_no_resp", saw, 1'b0);
        issue(vt[3]);
        wait_idle();

        check32("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
